// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: samples a BCD word once per frame and
// multiplexes it onto eSeg/anode with leading-zero blanking, per-digit blink and enable.
module seg7_scan_driver #(
  parameter int DIGIT_PERIOD = 12500,
  parameter int BLINK_PERIOD = 12500000
) (
  input  logic        clk_osc,
  input  logic        RESET,
  input  logic [15:0] num,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [3:0]  blink_mask,
  output logic [6:0]  eSeg,
  output logic [3:0]  anode,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int TICK_W  = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIGIT_PERIOD - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);

  logic [TICK_W-1:0]  tick_r;
  logic [1:0]         digit_r;
  logic [15:0]        shadow_r;
  logic               frame_done_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_phase_r;
  logic [6:0]         eseg_r;
  logic [3:0]         anode_r;

  logic               tick_tc_s;
  logic               blink_tc_s;
  logic [3:0]         nibble_s;
  logic [3:0]         lz_blank_s;
  logic               digit_on_s;
  logic [6:0]         eseg_s;
  logic [3:0]         anode_s;

  // Active-low gfedcba pattern; non-BCD nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
    return seg;
  endfunction

  assign tick_tc_s  = (tick_r == TICK_LAST);
  assign blink_tc_s = (blink_cnt_r == BLINK_LAST);

  // Digit slot timer, digit sequencer and frame-boundary capture of num.
  always_ff @(posedge clk_osc) begin
    if (RESET) begin
      tick_r       <= '0;
      digit_r      <= 2'd0;
      shadow_r     <= 16'h0000;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (tick_tc_s) begin
        tick_r  <= '0;
        digit_r <= digit_r + 2'd1;
        if (digit_r == 2'd3) begin
          shadow_r     <= num;
          frame_done_r <= 1'b1;
        end
      end else begin
        tick_r <= tick_r + TICK_W'(1);
      end
    end
  end

  // Free-running blink phase generator.
  always_ff @(posedge clk_osc) begin
    if (RESET) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (blink_tc_s) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
    end
  end

  // Select the active nibble and decide whether its digit is lit.
  always_comb begin
    nibble_s   = 4'h0;
    lz_blank_s = 4'b0000;
    anode_s    = 4'b1111;
    eseg_s     = 7'b1111111;
    case (digit_r)
      2'd0:    nibble_s = shadow_r[3:0];
      2'd1:    nibble_s = shadow_r[7:4];
      2'd2:    nibble_s = shadow_r[11:8];
      2'd3:    nibble_s = shadow_r[15:12];
      default: nibble_s = 4'h0;
    endcase
    // A digit is a leading zero only if it and every digit to its left are zero.
    lz_blank_s[3] = blank_lz & (shadow_r[15:12] == 4'h0);
    lz_blank_s[2] = lz_blank_s[3] & (shadow_r[11:8] == 4'h0);
    lz_blank_s[1] = lz_blank_s[2] & (shadow_r[7:4] == 4'h0);
    lz_blank_s[0] = 1'b0;
    digit_on_s = enable & ~lz_blank_s[digit_r] & ~(blink_mask[digit_r] & blink_phase_r);
    if (digit_on_s) begin
      anode_s = ~(4'b0001 << digit_r);
      eseg_s  = seg_decode(nibble_s);
    end else begin
      anode_s = 4'b1111;
      eseg_s  = 7'b1111111;
    end
  end

  // Segment and anode lines update together from one register stage.
  always_ff @(posedge clk_osc) begin
    if (RESET) begin
      anode_r <= 4'b1111;
      eseg_r  <= 7'b1111111;
    end else begin
      anode_r <= anode_s;
      eseg_r  <= eseg_s;
    end
  end

  assign eSeg       = eseg_r;
  assign anode      = anode_r;
  assign digit_idx  = digit_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with short digit and blink periods.
module tb_seg7_scan_driver;

  logic        clk_osc = 1'b0;
  logic        RESET;
  logic [15:0] num;
  logic        enable;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [6:0]  eSeg;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0]  SEG_OFF = 7'b1111111;
  localparam logic [15:0] AN_ALL  = 16'b0111_1011_1101_1110;

  seg7_scan_driver #(.DIGIT_PERIOD(4), .BLINK_PERIOD(64)) dut (
    .clk_osc    (clk_osc),
    .RESET      (RESET),
    .num        (num),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .eSeg       (eSeg),
    .anode      (anode),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk_osc = ~clk_osc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_osc);
    #1;
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 40);
    check_val(tag, 32'(frame_done), 32'd1);
  endtask

  // Starts in a frame_done cycle; checks the four slots of the following frame.
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [15:0] anodes,
                             input logic chg, input logic [15:0] chg_num);
    for (int d = 0; d < 4; d++) begin
      step();
      if (chg && d == 1) num = chg_num;
      check_val($sformatf("%s_an_first_d%0d", tag, d), 32'(anode), 32'(anodes[d*4 +: 4]));
      check_val($sformatf("%s_seg_first_d%0d", tag, d), 32'(eSeg), 32'(segs[d*7 +: 7]));
      check_val($sformatf("%s_idx_d%0d", tag, d), 32'(digit_idx), 32'(d));
      if (d == 0) check_val($sformatf("%s_fd_low", tag), 32'(frame_done), 32'd0);
      repeat (3) step();
      check_val($sformatf("%s_an_last_d%0d", tag, d), 32'(anode), 32'(anodes[d*4 +: 4]));
      check_val($sformatf("%s_seg_last_d%0d", tag, d), 32'(eSeg), 32'(segs[d*7 +: 7]));
    end
    check_val($sformatf("%s_fd_period", tag), 32'(frame_done), 32'd1);
  endtask

  initial begin
    int d;
    int ph;
    logic       lit;
    logic [3:0] one_hot;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    RESET      = 1'b1;
    num        = 16'h0000;
    enable     = 1'b1;
    blank_lz   = 1'b0;
    blink_mask = 4'b0000;

    // 1: reset state and first displayed digit
    repeat (10) step();
    check_val("rst_anode", 32'(anode), 32'hF);
    check_val("rst_eseg", 32'(eSeg), 32'(SEG_OFF));
    check_val("rst_fd", 32'(frame_done), 32'd0);
    check_val("rst_idx", 32'(digit_idx), 32'd0);
    RESET = 1'b0;
    repeat (2) step();
    check_val("rel_anode", 32'(anode), 32'b1110);
    check_val("rel_eseg", 32'(eSeg), 32'b1000000);

    // 2: 1234 scanned digit by digit
    num = 16'h1234;
    wait_frame("t2_frame");
    check_frame("t2", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, AN_ALL, 1'b0, 16'h0);

    // 3: mid-frame change is held off until the next capture
    check_frame("t3_hold", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, AN_ALL, 1'b1, 16'h5678);
    check_frame("t3_new", {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, AN_ALL, 1'b0, 16'h0);

    // 4: leading-zero blanking
    blank_lz = 1'b1;
    num      = 16'h0050;
    wait_frame("t4_frame_a");
    check_frame("t4_0050", {SEG_OFF, SEG_OFF, 7'b0010010, 7'b1000000},
                16'b1111_1111_1101_1110, 1'b0, 16'h0);
    num = 16'h0000;
    wait_frame("t4_frame_b");
    check_frame("t4_0000", {SEG_OFF, SEG_OFF, SEG_OFF, 7'b1000000},
                16'b1111_1111_1111_1110, 1'b0, 16'h0);

    // 5: blink on digit 0, counted from a fresh reset; then enable low
    blank_lz   = 1'b0;
    blink_mask = 4'b0001;
    RESET      = 1'b1;
    step();
    RESET = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      step();
      d       = ((k - 1) / 4) % 4;
      ph      = ((k - 1) / 64) % 2;
      lit     = !(d == 0 && ph == 1);
      one_hot = 4'b0001 << d;
      exp_an  = lit ? ~one_hot : 4'b1111;
      exp_seg = lit ? 7'b1000000 : SEG_OFF;
      check_val($sformatf("t5_blink_an_k%0d", k), 32'(anode), 32'(exp_an));
      check_val($sformatf("t5_blink_seg_k%0d", k), 32'(eSeg), 32'(exp_seg));
    end
    enable = 1'b0;
    for (int k = 257; k <= 288; k++) begin
      step();
      check_val($sformatf("t5_dis_an_k%0d", k), 32'(anode), 32'hF);
      check_val($sformatf("t5_dis_idx_k%0d", k), 32'(digit_idx), 32'((k / 4) % 4));
    end

    // 6: non-BCD nibble, then reset mid-frame
    enable     = 1'b1;
    blink_mask = 4'b0000;
    num        = 16'hA000;
    wait_frame("t6_frame");
    check_frame("t6_A000", {7'b0111111, 7'b1000000, 7'b1000000, 7'b1000000}, AN_ALL, 1'b0, 16'h0);
    repeat (6) step();
    RESET = 1'b1;
    step();
    check_val("t6_rst_anode", 32'(anode), 32'hF);
    check_val("t6_rst_eseg", 32'(eSeg), 32'(SEG_OFF));
    check_val("t6_rst_idx", 32'(digit_idx), 32'd0);
    check_val("t6_rst_fd", 32'(frame_done), 32'd0);
    RESET = 1'b0;
    step();
    check_val("t6_rel_anode", 32'(anode), 32'b1110);
    check_val("t6_rel_eseg", 32'(eSeg), 32'b1000000);
    repeat (12) step();
    check_val("t6_d3_shadow0_an", 32'(anode), 32'b0111);
    check_val("t6_d3_shadow0_seg", 32'(eSeg), 32'b1000000);
    repeat (3) step();
    check_val("t6_first_fd", 32'(frame_done), 32'd1);
    repeat (13) step();
    check_val("t6_d3_dash_an", 32'(anode), 32'b0111);
    check_val("t6_d3_dash_seg", 32'(eSeg), 32'b0111111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
